// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative RV32M multiply/divide unit for the execute stage. It takes one
// operation at a time and runs it over a private adder:
//   - multiply: WIDTH-cycle shift-add of operand magnitudes
//   - divide:   WIDTH-cycle restoring division of operand magnitudes
// The sign fix-up happens in a final FIXUP cycle. While an operation is in
// flight the upstream pipeline is held through 'stall'.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, qualified with Funct3/SrcA/SrcB
//   Funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA    in   rs1 operand (multiplicand / dividend)
//   SrcB    in   rs2 operand (multiplier / divisor)
//   flush   in   synchronous abort from the pipeline
//   Result  out  registered result, held until the next completion
//   done    out  one-cycle pulse, Result valid in that cycle
//   busy    out  high whenever the sequencer is not idle
//   stall   out  combinational hold request for upstream stages
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic [WIDTH-1:0] Result,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Two's complement negation at WIDTH bits.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation at full product width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t               state_r;
  state_t               state_s;
  logic [2:0]           funct3_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 sign_a_r;
  logic                 sign_b_r;
  logic [WIDTH-1:0]     mag_a_r;
  logic [WIDTH-1:0]     mag_b_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [WIDTH:0]       rem_r;
  logic [WIDTH-1:0]     quo_r;
  logic [WIDTH-1:0]     result_r;
  logic                 done_r;
  logic                 busy_r;

  // Operand decode / special-case detection (valid in PREP)
  logic                 signed_a_s;
  logic                 signed_b_s;
  logic                 sign_a_s;
  logic                 sign_b_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic                 div_zero_s;
  logic                 overflow_s;
  logic [WIDTH-1:0]     special_res_s;

  // Shared adder
  logic [WIDTH+1:0]     add_a_s;
  logic [WIDTH+1:0]     add_b_s;
  logic                 add_cin_s;
  logic [WIDTH+1:0]     add_sum_s;
  logic                 trial_neg_s;

  // Fix-up and result write
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic [WIDTH-1:0]     fix_res_s;
  logic                 accept_s;
  logic                 wr_s;
  logic [WIDTH-1:0]     wr_val_s;

  assign accept_s = (state_r == IDLE) && start && !flush;

  // Operand signedness per opcode; MULHSU treats only rs1 as signed.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (funct3_r)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      3'b010: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b0;
      end
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
  end

  // Signs, magnitudes and the two divide short-cuts.
  always_comb begin
    sign_a_s   = signed_a_s & a_r[WIDTH-1];
    sign_b_s   = signed_b_s & b_r[WIDTH-1];
    mag_a_s    = sign_a_s ? neg_w(a_r) : a_r;
    mag_b_s    = sign_b_s ? neg_w(b_r) : b_r;
    div_zero_s = funct3_r[2] && (b_r == ZERO_W);
    // Only the signed forms (DIV, REM) can overflow.
    overflow_s = funct3_r[2] && !funct3_r[0] && (a_r == MIN_NEG_W) && (b_r == ONES_W);
    if (div_zero_s) begin
      special_res_s = funct3_r[1] ? a_r : ONES_W;
    end else begin
      special_res_s = funct3_r[1] ? ZERO_W : MIN_NEG_W;
    end
  end

  // Private adder: trial subtraction for divide, partial-product add for multiply.
  always_comb begin
    if (funct3_r[2]) begin
      // Shift the next dividend bit into the remainder and subtract the
      // divisor; the extra top bit flags a negative trial.
      add_a_s   = {rem_r, quo_r[WIDTH-1]};
      add_b_s   = ~{2'b00, mag_b_r};
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = {2'b00, prod_r[2*WIDTH-1:WIDTH]};
      add_b_s   = prod_r[0] ? {2'b00, mag_a_r} : {(WIDTH+2){1'b0}};
      add_cin_s = 1'b0;
    end
    add_sum_s   = add_a_s + add_b_s + {{(WIDTH+1){1'b0}}, add_cin_s};
    trial_neg_s = add_sum_s[WIDTH+1];
  end

  // Sign restoration and output selection for the FIXUP cycle.
  always_comb begin
    prod_fix_s = (sign_a_r ^ sign_b_r) ? neg_2w(prod_r) : prod_r;
    quo_fix_s  = (sign_a_r ^ sign_b_r) ? neg_w(quo_r) : quo_r;
    // Remainder follows the sign of the dividend.
    rem_fix_s  = sign_a_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
    case (funct3_r)
      3'b000:                 fix_res_s = prod_fix_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res_s = quo_fix_s;
      default:                fix_res_s = rem_fix_s;
    endcase
  end

  // Next-state logic and result write strobe.
  always_comb begin
    state_s  = state_r;
    wr_s     = 1'b0;
    wr_val_s = fix_res_s;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = PREP;
        end else begin
          state_s = IDLE;
        end
      end
      PREP: begin
        if (flush) begin
          state_s = IDLE;
        end else if (div_zero_s || overflow_s) begin
          state_s  = DONE;
          wr_s     = 1'b1;
          wr_val_s = special_res_s;
        end else begin
          state_s = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = FIXUP;
        end else begin
          state_s = CALC;
        end
      end
      FIXUP: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
          wr_s    = 1'b1;
        end
      end
      DONE: begin
        // The result is already committed, so a flush here changes nothing.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus registered done/busy derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Operand capture, magnitude setup and the per-cycle iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_r <= 3'b000;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      mag_a_r  <= ZERO_W;
      mag_b_r  <= ZERO_W;
      cnt_r    <= CNT_ZERO;
      prod_r   <= {(2*WIDTH){1'b0}};
      rem_r    <= {(WIDTH+1){1'b0}};
      quo_r    <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            funct3_r <= Funct3;
            a_r      <= SrcA;
            b_r      <= SrcB;
          end else begin
            funct3_r <= funct3_r;
          end
        end
        PREP: begin
          sign_a_r <= sign_a_s;
          sign_b_r <= sign_b_s;
          mag_a_r  <= mag_a_s;
          mag_b_r  <= mag_b_s;
          cnt_r    <= CNT_LOAD;
          // Multiplier sits in the low half and is consumed LSB first.
          prod_r   <= {ZERO_W, mag_b_s};
          // Dividend is shifted out of the quotient register MSB first.
          quo_r    <= mag_a_s;
          rem_r    <= {(WIDTH+1){1'b0}};
        end
        CALC: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (funct3_r[2]) begin
            if (trial_neg_s) begin
              rem_r <= add_a_s[WIDTH:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end else begin
              rem_r <= add_sum_s[WIDTH:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end
          end else begin
            prod_r <= {add_sum_s[WIDTH:0], prod_r[WIDTH-1:1]};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result register, written only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= ZERO_W;
    end else if (wr_s) begin
      result_r <= wr_val_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign Result = result_r;
  assign done   = done_r;
  assign busy   = busy_r;
  // Stall must cover the accept cycle itself, so it is decoded from the
  // current state and the live request.
  assign stall  = accept_s || (state_r == PREP) || (state_r == CALC) || (state_r == FIXUP);

endmodule
